// File: rtl/controller_sequencer_if.sv
// Host-side handshake and step-count bundle of the tanh-unit controller sequencer.
// The master drives start/hold/abort; the slave (the sequencer) drives count and status.
interface controller_sequencer_if;
    logic        start;
    logic        hold;
    logic        abort;
    logic [12:0] count;
    logic        enable;
    logic        done;
    logic        start_err;
    logic [15:0] stall_cycles;

    modport master (
        output start,
        output hold,
        output abort,
        input  count,
        input  enable,
        input  done,
        input  start_err,
        input  stall_cycles
    );

    modport slave (
        input  start,
        input  hold,
        input  abort,
        output count,
        output enable,
        output done,
        output start_err,
        output stall_cycles
    );
endinterface

// File: rtl/controller_sequencer.sv
// Step-count sequencer for one tanh-unit pass: start/done handshake, slot-boundary stall, abort.
// Optional hold-cycle counter enabled by defining SEQ_STALL_CNT_EN.
module controller_sequencer #(
    parameter logic [12:0] END_COUNT = 13'h100F
) (
    input  logic                   clk,
    input  logic                   rst_n,
    controller_sequencer_if.slave  seq_if
);

    localparam int unsigned CNT_W = 13;

    typedef enum logic [1:0] {StIdle, StRun, StHold, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic             enable_q;
    logic             done_q;
    logic             start_err_q;
    // Start seen during the DONE cycle; launches RUN after the following IDLE cycle.
    logic             pending_q;

    logic slot_end;
    assign slot_end = (count_q[3:0] == 4'hF);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            count_q     <= '0;
            enable_q    <= 1'b0;
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            pending_q   <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            start_err_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    // Abort is meaningless here, so start always wins.
                    if (seq_if.start || pending_q) begin
                        state_q   <= StRun;
                        count_q   <= '0;
                        enable_q  <= 1'b1;
                        pending_q <= 1'b0;
                    end
                end
                StRun: begin
                    if (seq_if.start) begin
                        start_err_q <= 1'b1;
                    end
                    if (seq_if.abort) begin
                        state_q  <= StIdle;
                        count_q  <= '0;
                        enable_q <= 1'b0;
                    end else if (count_q == END_COUNT) begin
                        state_q  <= StDone;
                        enable_q <= 1'b0;
                    end else if (slot_end && seq_if.hold) begin
                        // Phase F carries no strobe, so freezing here has no side effects.
                        state_q <= StHold;
                    end else begin
                        count_q <= count_q + 13'd1;
                    end
                end
                StHold: begin
                    if (seq_if.start) begin
                        start_err_q <= 1'b1;
                    end
                    if (seq_if.abort) begin
                        state_q  <= StIdle;
                        count_q  <= '0;
                        enable_q <= 1'b0;
                    end else if (!seq_if.hold) begin
                        state_q <= StRun;
                        count_q <= count_q + 13'd1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                    done_q  <= 1'b1;
                    count_q <= '0;
                    if (seq_if.start) begin
                        pending_q <= 1'b1;
                    end
                end
                default: begin
                    state_q  <= StIdle;
                    count_q  <= '0;
                    enable_q <= 1'b0;
                end
            endcase
        end
    end

    assign seq_if.count     = count_q;
    assign seq_if.enable    = enable_q;
    assign seq_if.done      = done_q;
    assign seq_if.start_err = start_err_q;

`ifdef SEQ_STALL_CNT_EN
    logic [15:0] stall_q;
    logic        start_accept;

    assign start_accept = (state_q == StIdle) && (seq_if.start || pending_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (start_accept) begin
            stall_q <= '0;
        end else if ((state_q == StHold) && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
        end
    end

    assign seq_if.stall_cycles = stall_q;
`else
    assign seq_if.stall_cycles = 16'h0;
`endif

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed self-checking bench for controller_sequencer.
// Expected stall counts follow SEQ_STALL_CNT_EN when it is defined for the build.
module tb_controller_sequencer;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    controller_sequencer_if bus ();

    controller_sequencer dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .seq_if (bus)
    );

`ifdef SEQ_STALL_CNT_EN
    localparam bit StallEn = 1'b1;
`else
    localparam bit StallEn = 1'b0;
`endif

    int tests = 0;
    int fails = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for a count value; an expired bound is a failure.
    task automatic wait_count(input logic [12:0] target, input int budget);
        int n;
        n = 0;
        while (bus.count !== target && n < budget) begin
            tick();
            n++;
        end
        tests++;
        if (bus.count !== target) begin
            $display("FAIL wait_count: count=%h, required %h within %0d cycles", bus.count, target,
                     budget);
            fails++;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus.hold  = 1'b0;
        bus.abort = 1'b0;
        rst_n     = 1'b0;
        repeat (3) tick();
        tests++;
        if (bus.count !== 13'h0 || bus.enable !== 1'b0 || bus.done !== 1'b0 ||
            bus.start_err !== 1'b0 || bus.stall_cycles !== 16'h0) begin
            $display("FAIL reset_values: count=%h en=%b done=%b err=%b stall=%h, required all zero",
                     bus.count, bus.enable, bus.done, bus.start_err, bus.stall_cycles);
            fails++;
        end
        rst_n = 1'b1;
        repeat (3) tick();
        tests++;
        if (bus.count !== 13'h0 || bus.enable !== 1'b0) begin
            $display("FAIL idle_after_reset: count=%h en=%b, required 0/0", bus.count, bus.enable);
            fails++;
        end
    endtask

    task automatic test_basic_pass();
        logic [12:0] exp;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tests++;
        if (bus.count !== 13'h0 || bus.enable !== 1'b1) begin
            $display("FAIL start_latency: count=%h en=%b, required 0/1", bus.count, bus.enable);
            fails++;
        end
        for (int k = 1; k <= 13'h100F; k++) begin
            exp = k[12:0];
            tick();
            tests++;
            if (bus.count !== exp || bus.enable !== 1'b1 || bus.done !== 1'b0) begin
                $display("FAIL pass_step: count=%h en=%b done=%b, required %h/1/0", bus.count,
                         bus.enable, bus.done, exp);
                fails++;
                break;
            end
        end
        tick();
        tests++;
        if (bus.count !== 13'h100F || bus.enable !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL pass_end: count=%h en=%b done=%b, required 100f/0/0", bus.count,
                     bus.enable, bus.done);
            fails++;
        end
        tick();
        tests++;
        if (bus.done !== 1'b1 || bus.count !== 13'h0 || bus.enable !== 1'b0) begin
            $display("FAIL done_pulse: done=%b count=%h en=%b, required 1/0/0", bus.done,
                     bus.count, bus.enable);
            fails++;
        end
        tick();
        tests++;
        if (bus.done !== 1'b0 || bus.enable !== 1'b0) begin
            $display("FAIL done_width: done=%b en=%b, required 0/0", bus.done, bus.enable);
            fails++;
        end
    endtask

    task automatic test_boundary_hold();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_count(13'h0035, 100);
        bus.hold = 1'b1;
        repeat (10) tick();
        tick();
        tests++;
        if (bus.count !== 13'h003F) begin
            $display("FAIL hold_enter: count=%h, required 003f", bus.count);
            fails++;
        end
        repeat (5) tick();
        tests++;
        if (bus.count !== 13'h003F || bus.enable !== 1'b1) begin
            $display("FAIL hold_frozen: count=%h en=%b, required 003f/1", bus.count, bus.enable);
            fails++;
        end
        bus.hold = 1'b0;
        tick();
        tests++;
        if (bus.count !== 13'h0040) begin
            $display("FAIL hold_release: count=%h, required 0040", bus.count);
            fails++;
        end
        tests++;
        if (bus.stall_cycles !== (StallEn ? 16'd6 : 16'd0)) begin
            $display("FAIL stall_count_a: stall=%0d, required %0d", bus.stall_cycles,
                     StallEn ? 6 : 0);
            fails++;
        end
    endtask

    task automatic test_midslot_hold();
        wait_count(13'h0047, 20);
        bus.hold = 1'b1;
        tick();
        tests++;
        if (bus.count !== 13'h0048) begin
            $display("FAIL midslot_ignored: count=%h, required 0048", bus.count);
            fails++;
        end
        repeat (7) tick();
        tick();
        tests++;
        if (bus.count !== 13'h004F) begin
            $display("FAIL midslot_freeze: count=%h, required 004f", bus.count);
            fails++;
        end
        bus.hold = 1'b0;
        tick();
        tests++;
        if (bus.count !== 13'h0050 || bus.stall_cycles !== (StallEn ? 16'd7 : 16'd0)) begin
            $display("FAIL midslot_release: count=%h stall=%0d, required 0050/%0d", bus.count,
                     bus.stall_cycles, StallEn ? 7 : 0);
            fails++;
        end
    endtask

    task automatic test_abort();
        wait_count(13'h0123, 300);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        tests++;
        if (bus.count !== 13'h0 || bus.enable !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL abort_exit: count=%h en=%b done=%b, required 0/0/0", bus.count,
                     bus.enable, bus.done);
            fails++;
        end
        repeat (3) tick();
        tests++;
        if (bus.done !== 1'b0 || bus.enable !== 1'b0 ||
            bus.stall_cycles !== (StallEn ? 16'd7 : 16'd0)) begin
            $display("FAIL abort_quiet: done=%b en=%b stall=%0d, required 0/0/%0d", bus.done,
                     bus.enable, bus.stall_cycles, StallEn ? 7 : 0);
            fails++;
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tests++;
        if (bus.enable !== 1'b1 || bus.count !== 13'h0 || bus.stall_cycles !== 16'h0) begin
            $display("FAIL restart: en=%b count=%h stall=%0d, required 1/0/0", bus.enable,
                     bus.count, bus.stall_cycles);
            fails++;
        end
        wait_count(13'h100F, 13'h1100);
        // Termination outranks a hold request at the final phase-F count.
        bus.hold = 1'b1;
        tick();
        bus.hold = 1'b0;
        tests++;
        if (bus.enable !== 1'b0 || bus.count !== 13'h100F) begin
            $display("FAIL end_beats_hold: en=%b count=%h, required 0/100f", bus.enable,
                     bus.count);
            fails++;
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tests++;
        if (bus.done !== 1'b1 || bus.count !== 13'h0 || bus.enable !== 1'b0 ||
            bus.start_err !== 1'b0) begin
            $display("FAIL done_start_idle: done=%b count=%h en=%b err=%b, required 1/0/0/0",
                     bus.done, bus.count, bus.enable, bus.start_err);
            fails++;
        end
        tick();
        tests++;
        if (bus.enable !== 1'b1 || bus.count !== 13'h0 || bus.done !== 1'b0) begin
            $display("FAIL done_start_run: en=%b count=%h done=%b, required 1/0/0", bus.enable,
                     bus.count, bus.done);
            fails++;
        end
    endtask

    task automatic test_busy_start();
        wait_count(13'h0200, 13'h0300);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tests++;
        if (bus.start_err !== 1'b1 || bus.count !== 13'h0201) begin
            $display("FAIL busy_start_err: err=%b count=%h, required 1/0201", bus.start_err,
                     bus.count);
            fails++;
        end
        tick();
        tests++;
        if (bus.start_err !== 1'b0 || bus.count !== 13'h0202 || bus.enable !== 1'b1) begin
            $display("FAIL busy_start_clear: err=%b count=%h en=%b, required 0/0202/1",
                     bus.start_err, bus.count, bus.enable);
            fails++;
        end
        bus.abort = 1'b1;
        tick();
        tests++;
        if (bus.enable !== 1'b0) begin
            $display("FAIL busy_abort: en=%b, required 0", bus.enable);
            fails++;
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        tests++;
        if (bus.enable !== 1'b1 || bus.count !== 13'h0) begin
            $display("FAIL start_abort_idle: en=%b count=%h, required 1/0", bus.enable, bus.count);
            fails++;
        end
    endtask

    task automatic test_reset_midpass();
        wait_count(13'h0800, 13'h0900);
        #2;
        rst_n = 1'b0;
        #1;
        tests++;
        if (bus.count !== 13'h0 || bus.enable !== 1'b0 || bus.done !== 1'b0 ||
            bus.start_err !== 1'b0 || bus.stall_cycles !== 16'h0) begin
            $display("FAIL async_reset: count=%h en=%b done=%b err=%b stall=%h, required zeros",
                     bus.count, bus.enable, bus.done, bus.start_err, bus.stall_cycles);
            fails++;
        end
        tick();
        rst_n = 1'b1;
        repeat (3) tick();
        tests++;
        if (bus.count !== 13'h0 || bus.enable !== 1'b0 || bus.done !== 1'b0) begin
            $display("FAIL reset_waits: count=%h en=%b done=%b, required 0/0/0", bus.count,
                     bus.enable, bus.done);
            fails++;
        end
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tests++;
        if (bus.enable !== 1'b1 || bus.count !== 13'h1) begin
            $display("FAIL reset_restart: en=%b count=%h, required 1/0001", bus.enable, bus.count);
            fails++;
        end
    endtask

    initial begin
        test_reset();
        test_basic_pass();
        test_boundary_hold();
        test_midslot_hold();
        test_abort();
        test_busy_start();
        test_reset_midpass();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
